// File: rtl/login_controller.sv
// login_controller: sequences one login request at a time through the
// combinational password verifier, reports grant/deny and tracks
// consecutive failures.
// Optional lockout: define LOGIN_LOCKOUT_EN to enable the timed LOCKED
// state. Without it, locked is tied 0 but fail_count still saturates.
module login_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_FAILS     = 3,
  parameter int LOCK_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] username_in,
  input  logic [63:0] password_in,
  output logic [63:0] ver_username,
  output logic [63:0] ver_password,
  input  logic        ver_valid,
  output logic        busy,
  output logic        done,
  output logic        granted,
  output logic        denied,
  output logic        locked,
  output logic        start_rejected,
  output logic [2:0]  fail_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    MAX_FC      = 3'(MAX_FAILS);

  typedef enum logic [1:0] {IDLE, CHECK, RESULT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [63:0]   user_q, user_d;
  logic [63:0]   pass_q, pass_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          granted_q, granted_d;
  logic          denied_q, denied_d;
  logic          rej_q, rej_d;
  logic [2:0]    fail_q, fail_d;
`ifdef LOGIN_LOCKOUT_EN
  localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);
  logic [15:0]   lock_q, lock_d;
  logic          locked_q, locked_d;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    user_d    = user_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    done_d    = 1'b0;
    granted_d = 1'b0;
    denied_d  = 1'b0;
    rej_d     = start && (state_q != IDLE);
`ifdef LOGIN_LOCKOUT_EN
    lock_d    = lock_q;
    locked_d  = locked_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          user_d   = username_in;
          pass_d   = password_in;
          settle_d = SETTLE_LOAD;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // ver_valid only matters on the last settle edge; earlier glitches are ignored.
        if (settle_q == '0) begin
          state_d   = RESULT;
          done_d    = 1'b1;
          granted_d = ver_valid;
          denied_d  = !ver_valid;
          if (ver_valid)
            fail_d = 3'd0;
          else if (fail_q != MAX_FC)
            fail_d = fail_q + 3'd1;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      RESULT: begin
        state_d = IDLE;
`ifdef LOGIN_LOCKOUT_EN
        if (denied_q && (fail_q == MAX_FC)) begin
          state_d  = LOCKED;
          lock_d   = LOCK_LOAD;
          locked_d = 1'b1;
        end
`endif
      end
      LOCKED: begin
`ifdef LOGIN_LOCKOUT_EN
        if (lock_q == 16'd0) begin
          state_d  = IDLE;
          fail_d   = 3'd0;
          locked_d = 1'b0;
        end else begin
          lock_d = lock_q - 16'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any request without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      user_q    <= '0;
      pass_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      rej_q     <= 1'b0;
      fail_q    <= 3'd0;
`ifdef LOGIN_LOCKOUT_EN
      lock_q    <= 16'd0;
      locked_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      user_q    <= user_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      granted_q <= granted_d;
      denied_q  <= denied_d;
      rej_q     <= rej_d;
      fail_q    <= fail_d;
`ifdef LOGIN_LOCKOUT_EN
      lock_q    <= lock_d;
      locked_q  <= locked_d;
`endif
    end
  end

  assign ver_username   = user_q;
  assign ver_password   = pass_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign granted        = granted_q;
  assign denied         = denied_q;
  assign start_rejected = rej_q;
  assign fail_count     = fail_q;
`ifdef LOGIN_LOCKOUT_EN
  assign locked         = locked_q;
`else
  assign locked         = 1'b0;
`endif

endmodule

// File: doc/login_controller.md
Name: login_controller

Overview:
- Sequencer that owns the combinational password verifier: accepts one login request at a time, holds username/password stable on the verifier inputs for a fixed settle window, samples the verifier's valid result, and reports grant or deny.
- Tracks consecutive failed attempts and enforces a timed lockout.
- Sits between the user-input front end (switch/keypad capture) and the verifier datapath.

Parameters:
- SETTLE_CYCLES, 2, cycles the verifier inputs are held before its result is sampled (≥1).
- MAX_FAILS, 3, consecutive failures that trigger lockout (1..7).
- LOCK_CYCLES, 1000, lockout duration in clock cycles (1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled each rising edge.
- username_in  input  64  username, captured when start is accepted.
- password_in  input  64  password, captured when start is accepted.
- ver_username  output  64  registered username driven to the verifier.
- ver_password  output  64  registered password driven to the verifier.
- ver_valid  input  1  verifier result (combinational from ver_*).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a result is reported.
- granted  output  1  one-cycle pulse coincident with done on success.
- denied  output  1  one-cycle pulse coincident with done on failure.
- locked  output  1  high while in LOCKED.
- start_rejected  output  1  one-cycle pulse when start is seen outside IDLE.
- fail_count  output  3  consecutive failure count.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0; ver_username and ver_password are 0.
  - Fail counter, settle counter and lock counter are 0.
  - Reset asserted mid-operation aborts the request with no done pulse.
- States: IDLE, CHECK, RESULT, LOCKED. All outputs are registered.
- IDLE:
  - start=1 at edge E0 latches username_in/password_in into ver_*, loads the settle counter with SETTLE_CYCLES-1, and enters CHECK.
  - ver_* are held constant until the next accepted start.
- CHECK:
  - Settle counter decrements each edge.
  - At the edge where it is 0 (edge E_SETTLE_CYCLES), ver_valid is sampled and the state moves to RESULT.
- RESULT (one cycle):
  - done=1, plus exactly one of granted/denied.
  - With SETTLE_CYCLES=2, done is high in the cycle after E2.
- Fail counter arithmetic:
  - Success clears fail_count to 0.
  - Failure increments it, saturating at MAX_FAILS.
- Exit from RESULT:
  - On failure, if fail_count becomes MAX_FAILS, enter LOCKED and load the lock counter with LOCK_CYCLES-1.
  - Otherwise return to IDLE.
- LOCKED:
  - locked=1, busy=1; the lock counter decrements each edge.
  - When the counter is 0, next state is IDLE, fail_count clears to 0 and locked drops.
- start outside IDLE (CHECK, RESULT, LOCKED):
  - Ignored; ver_* are unchanged.
  - start_rejected pulses in the cycle after each such edge.
- start held high continuously:
  - Accepted at every IDLE edge; the new request begins the cycle after RESULT returns to IDLE.
  - There is no edge detection.
- ver_valid is ignored in every state except the final CHECK edge. A glitch earlier in CHECK has no effect.

Optional Feature:
- Macro: LOGIN_LOCKOUT_EN.
- Defined: lockout behaves as described above.
- Undefined:
  - LOCKED is never entered and locked is tied 0.
  - fail_count still increments, saturates at MAX_FAILS and clears on success.

Test Plan:
- Reset then valid login:
  - Drive start=1 for 1 cycle with ver_valid forced 1 at the sample edge, SETTLE_CYCLES=2.
  - Expect done=1 and granted=1 exactly 3 edges after the start edge, then busy=0 and fail_count=0.
- Two failures then success:
  - ver_valid=0, 0, 1 on three requests.
  - Expect denied, denied, granted pulses and fail_count 1, 2, 0.
- Lockout (LOGIN_LOCKOUT_EN, MAX_FAILS=3, LOCK_CYCLES=10):
  - Three failures; expect locked=1 for 10 cycles, then locked=0 and fail_count=0.
  - A start during lockout gives start_rejected=1 and no done.
- Busy rejection:
  - A second start with a different username during CHECK.
  - Expect start_rejected pulse, ver_username still equal to the first value, and only one done.
- Reset mid-CHECK: pull rst_n low one cycle after an accepted start; expect all outputs 0 immediately (asynchronous) and no done afterwards.
- Macro undefined:
  - Five consecutive failures.
  - Expect locked never 1, fail_count saturates at 3, and each request produces a denied pulse.
